fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the processor execute stage. Holds the program counter, issues single-word read requests to the 4096 x 32 instruction/data memory, latches the returned word into an instruction register, splits it into decoded fields, and presents it to execute over a valid/ready handshake. Accepts branch redirects from execute and stops fetching after handing off a HLT instruction.

## Interface
- ADDR_W, 12: memory word-address width; PC width.
- DATA_W, 32: instruction word width.
- RESET_PC, 12'h100: PC value loaded at reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_ack  in  1  read data valid this cycle; may assert in the same cycle as mem_req.
- mem_rdata  in  DATA_W  read data; sampled only when mem_ack=1.
- instr_valid  out  1  instruction outputs valid.
- instr_ready  in  1  execute accepts the instruction.
- instr  out  DATA_W  raw instruction word.
- instr_pc  out  ADDR_W  address the instruction was fetched from.
- opcode  out  4  instr[31:28].
- cond  out  4  instr[27:24].
- src_imm  out  1  instr[27].
- dst_imm  out  1  instr[26].
- src_field  out  12  instr[23:12]: source address or shift count.
- dst_field  out  12  instr[11:0].
- redirect_valid  in  1  branch taken; one-cycle pulse.
- redirect_pc  in  ADDR_W  branch target.
- halted  out  1  HLT has been handed off; fetch stopped.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- Reset: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, halted=0, squash=0.
- IDLE -> FETCH unconditionally on the first clock. Entering FETCH loads mem_req=1 and mem_addr=pc.
- FETCH, mem_ack=1, squash=0: instr<=mem_rdata, instr_pc<=mem_addr, pc<=mem_addr+1 (modulo 2^ADDR_W, 12'hFFF -> 12'h000), mem_req<=0, instr_valid<=1, -> HOLD.
- FETCH, mem_ack=1, squash=1: discard data, squash<=0, reissue at pc (already the redirect target), stay in FETCH.
- FETCH, redirect_valid=1: pc<=redirect_pc. If no ack this cycle, squash<=1 and mem_req stays high at the old address until ack. A mid-transaction request is never withdrawn. Redirect with ack in the same cycle: data discarded, then refetch at redirect_pc.
- HOLD: the output registers are frozen while instr_valid=1 and instr_ready=0.
- HOLD, handshake (valid and ready) with opcode=4'h8 (HLT): instr_valid<=0, halted<=1, -> HALT. HLT takes priority over a redirect in the same cycle.
- HOLD, handshake with any other opcode: instr_valid<=0, -> FETCH at pc, or at redirect_pc if redirect_valid=1 in the same cycle.
- HOLD, redirect without handshake: instr_valid<=0, the held instruction is dropped, pc<=redirect_pc, -> FETCH.
- HALT: mem_req=0, instr_valid=0, redirect ignored. Only rst_n exits.
- Field outputs are a combinational decode of the instr register, so they are valid whenever instr_valid=1.
- Reset mid-operation: returns immediately to reset values. Any pending memory ack after reset is ignored because the block is in IDLE.

## Timing
- Single-cycle ack: request in cycle N, instr_valid in N+1, next mem_req in N+2 if ready was high in N+1. Peak throughput is one instruction per 2 cycles.
- Wait-state memory: instr_valid rises the cycle after mem_ack.
- Redirect latency: mem_req to the target is asserted in the cycle after redirect_valid (no outstanding request), or the cycle after the squashed ack.
- All outputs are registered except the decoded fields, which are combinational from instr.

## Structure
- Shared package proc_pkg:
  - opcode constants OP_NOP..OP_CMP (4'h0..4'h9);
  - condition codes CC_A..CC_PO (4'h0..4'h7);
  - RESET_PC default;
  - field bit-position constants.
- The execute stage uses the same package.
- Sub-module instr_field_decode: combinational splitter from the 32-bit word to opcode, cond, src_imm, dst_imm, src_field, dst_field. The execute stage reuses it.

## Test plan
- Reset release, single-cycle-ack memory, ready=1, mem[0x100]=0x1_0_005_006 -> first mem_addr=0x100; instr_valid one cycle later; opcode=1, src_field=0x005, dst_field=0x006, instr_pc=0x100; next mem_addr=0x101.
- Backpressure: ready=0 for 5 cycles -> instr, instr_pc and fields stable; no mem_req; fetch resumes the cycle after the handshake.
- Memory with 3 wait states plus redirect_valid to 0x200 during wait -> ack data at the old address dropped; mem_addr=0x200; the next valid instr_pc is 0x200.
- PC wrap: redirect to 0xFFF -> fetch 0xFFF, then mem_addr=0x000.
- HLT (0x80000000) handed off with a simultaneous redirect -> halted=1, mem_req=0 permanently; later redirects ignored; rst_n low restores mem_addr=0x100.
- rst_n asserted while in HOLD -> instr_valid=0, mem_req=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, condition codes,
// instruction field positions and fetch FSM state type.
package proc_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int FLD_W  = 12;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h100;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_STR = 4'h2;
  localparam logic [3:0] OP_BRA = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_ROT = 4'h6;
  localparam logic [3:0] OP_SHF = 4'h7;
  localparam logic [3:0] OP_HLT = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;

  localparam logic [3:0] CC_A  = 4'h0;
  localparam logic [3:0] CC_P  = 4'h1;
  localparam logic [3:0] CC_E  = 4'h2;
  localparam logic [3:0] CC_C  = 4'h3;
  localparam logic [3:0] CC_N  = 4'h4;
  localparam logic [3:0] CC_Z  = 4'h5;
  localparam logic [3:0] CC_NC = 4'h6;
  localparam logic [3:0] CC_PO = 4'h7;

  localparam int OPC_LSB  = 28;
  localparam int CC_LSB   = 24;
  localparam int SIMM_BIT = 27;
  localparam int DIMM_BIT = 26;
  localparam int SRC_LSB  = 12;
  localparam int DST_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [3:0]       cond;
    logic             src_imm;
    logic             dst_imm;
    logic [FLD_W-1:0] src_field;
    logic [FLD_W-1:0] dst_field;
  } instr_fields_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: memory read port, instruction
// handoff to execute, and branch redirect.
interface fetch_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [3:0]        opcode;
  logic [3:0]        cond;
  logic              src_imm;
  logic              dst_imm;
  logic [11:0]       src_field;
  logic [11:0]       dst_field;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr, instr_pc,
    output opcode, cond, src_imm, dst_imm,
    output src_field, dst_field,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output halted
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr, instr_pc,
    input  opcode, cond, src_imm, dst_imm,
    input  src_field, dst_field,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  halted
  );

endinterface

// File: rtl/fetch_unit_decode.sv
// Combinational instruction field splitter,
// shared by the fetch and execute stages.
module instr_field_decode
  import proc_pkg::*;
(
  input  logic [DATA_W-1:0] i_instr,
  output instr_fields_t     o_fields
);

  assign o_fields.opcode    = i_instr[OPC_LSB +: 4];
  assign o_fields.cond      = i_instr[CC_LSB +: 4];
  assign o_fields.src_imm   = i_instr[SIMM_BIT];
  assign o_fields.dst_imm   = i_instr[DIMM_BIT];
  assign o_fields.src_field = i_instr[SRC_LSB +: FLD_W];
  assign o_fields.dst_field = i_instr[DST_LSB +: FLD_W];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory read, instruction
// register and valid/ready handoff to execute.
module fetch_unit #(
  parameter int                ADDR_W   = proc_pkg::ADDR_W,
  parameter int                DATA_W   = proc_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  import proc_pkg::*;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic              r_mem_req;
  logic              w_mem_req_d;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_d;
  logic              r_instr_valid;
  logic              w_instr_valid_d;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] w_instr_d;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [ADDR_W-1:0] w_instr_pc_d;
  logic              r_halted;
  logic              w_halted_d;
  logic              r_squash;
  logic              w_squash_d;

  instr_fields_t     w_fields;
  logic              w_hs;
  logic              w_hlt;
  logic              w_redir;
  logic              w_ack;
  logic [ADDR_W-1:0] w_target;

  instr_field_decode u_dec (
    .i_instr  (r_instr),
    .o_fields (w_fields)
  );

  assign w_hs     = r_instr_valid & bus.instr_ready;
  assign w_hlt    = (w_fields.opcode == OP_HLT);
  assign w_redir  = bus.redirect_valid;
  assign w_ack    = bus.mem_ack;
  assign w_target = w_redir ? bus.redirect_pc : r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_ack && !r_squash && !w_redir)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_hs && w_hlt)
          w_state_nxt = S_HALT;
        else if (w_hs || w_redir)
          w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_d          = r_pc;
    w_mem_req_d     = r_mem_req;
    w_mem_addr_d    = r_mem_addr;
    w_instr_valid_d = r_instr_valid;
    w_instr_d       = r_instr;
    w_instr_pc_d    = r_instr_pc;
    w_halted_d      = r_halted;
    w_squash_d      = r_squash;
    unique case (r_state)
      S_IDLE: begin
        w_mem_req_d  = 1'b1;
        w_mem_addr_d = r_pc;
      end
      S_FETCH: begin
        // A request in flight is never withdrawn; stale data is dropped
        if (w_ack && (r_squash || w_redir)) begin
          w_pc_d       = w_target;
          w_mem_addr_d = w_target;
          w_squash_d   = 1'b0;
        end else if (w_ack) begin
          w_instr_d       = bus.mem_rdata;
          w_instr_pc_d    = r_mem_addr;
          w_pc_d          = r_mem_addr + 1'b1;
          w_mem_req_d     = 1'b0;
          w_instr_valid_d = 1'b1;
        end else if (w_redir) begin
          w_pc_d     = bus.redirect_pc;
          w_squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_hs && w_hlt) begin
          w_instr_valid_d = 1'b0;
          w_halted_d      = 1'b1;
        end else if (w_hs || w_redir) begin
          w_instr_valid_d = 1'b0;
          w_pc_d          = w_target;
          w_mem_req_d     = 1'b1;
          w_mem_addr_d    = w_target;
        end
      end
      S_HALT: begin
        w_mem_req_d     = 1'b0;
        w_instr_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_halted      <= 1'b0;
      r_squash      <= 1'b0;
    end else begin
      r_pc          <= w_pc_d;
      r_mem_req     <= w_mem_req_d;
      r_mem_addr    <= w_mem_addr_d;
      r_instr_valid <= w_instr_valid_d;
      r_instr       <= w_instr_d;
      r_instr_pc    <= w_instr_pc_d;
      r_halted      <= w_halted_d;
      r_squash      <= w_squash_d;
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.opcode      = w_fields.opcode;
  assign bus.cond        = w_fields.cond;
  assign bus.src_imm     = w_fields.src_imm;
  assign bus.dst_imm     = w_fields.dst_imm;
  assign bus.src_field   = w_fields.src_field;
  assign bus.dst_field   = w_fields.dst_field;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus a
// randomized run against a program-order fetch model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  fetch_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [4096];
  int waits = 0;
  int wcnt;
  int n_run = 0;
  int n_fail = 0;

  // Memory acks once a request has been held for `waits` cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wcnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else                                 wcnt <= 0;
  end

  assign bus.mem_ack   = bus.mem_req && (wcnt >= waits);
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    n_run++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req);
    end
    n_run++;
    if (bus.mem_addr !== 12'h000) begin
      n_fail++; $display("FAIL rst_mem_addr: got %h want 000", bus.mem_addr);
    end
    n_run++;
    if (bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid);
    end
    n_run++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 12'h0) begin
      n_fail++;
      $display("FAIL rst_instr: got %h/%h want 0/0", bus.instr, bus.instr_pc);
    end
    n_run++;
    if (bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL rst_halted: got %b want 0", bus.halted);
    end
  endtask

  task automatic test_first_fetch();
    waits = 0;
    bus.instr_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h100) begin
      n_fail++;
      $display("FAIL first_req: got %b@%h want 1@100", bus.mem_req, bus.mem_addr);
    end
    @(negedge clk);
    n_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h100) begin
      n_fail++;
      $display("FAIL first_valid: got %b pc %h want 1 pc 100",
               bus.instr_valid, bus.instr_pc);
    end
    n_run++;
    if (bus.opcode !== 4'h1 || bus.src_field !== 12'h005 ||
        bus.dst_field !== 12'h006) begin
      n_fail++;
      $display("FAIL first_fields: got %h %h %h want 1 005 006",
               bus.opcode, bus.src_field, bus.dst_field);
    end
    @(negedge clk);
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h101) begin
      n_fail++;
      $display("FAIL next_req: got %b@%h want 1@101", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s_instr;
    logic [11:0] s_pc;
    logic [27:0] s_fld;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    n_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h101 ||
        bus.instr !== mem[12'h101]) begin
      n_fail++;
      $display("FAIL bp_capture: got %b %h %h want 1 101 %h",
               bus.instr_valid, bus.instr_pc, bus.instr, mem[12'h101]);
    end
    s_instr = mem[12'h101];
    s_pc    = 12'h101;
    s_fld   = {s_instr[31:28], s_instr[23:0]};
    repeat (5) begin
      @(negedge clk);
      n_run++;
      if (bus.instr !== s_instr || bus.instr_pc !== s_pc ||
          {bus.opcode, bus.src_field, bus.dst_field} !== s_fld ||
          bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable: got %h %h v%b r%b want %h %h v1 r0",
                 bus.instr, bus.instr_pc, bus.instr_valid, bus.mem_req,
                 s_instr, s_pc);
      end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h102) begin
      n_fail++;
      $display("FAIL bp_resume: got %b@%h want 1@102", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    bit bad;
    int cyc;
    waits = 3;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bad = 1'b0;
    cyc = 0;
    while (bus.mem_addr === 12'h102 && cyc < 10) begin
      if (bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_run++;
    if (bad || cyc < 3) begin
      n_fail++;
      $display("FAIL redir_hold_old: got %0d cycles bad=%b want >=3 bad=0", cyc, bad);
    end
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h200 ||
        bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_target: got %b@%h v%b want 1@200 v0",
               bus.mem_req, bus.mem_addr, bus.instr_valid);
    end
    wait_valid(ok);
    n_run++;
    if (!ok || bus.instr_pc !== 12'h200 || bus.instr !== mem[12'h200]) begin
      n_fail++;
      $display("FAIL redir_instr: got ok=%b pc %h %h want pc 200 %h",
               ok, bus.instr_pc, bus.instr, mem[12'h200]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    waits = 0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'hFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 ||
        bus.mem_addr !== 12'hFFF) begin
      n_fail++;
      $display("FAIL wrap_req: got v%b %b@%h want v0 1@fff",
               bus.instr_valid, bus.mem_req, bus.mem_addr);
    end
    wait_valid(ok);
    n_run++;
    if (!ok || bus.instr_pc !== 12'hFFF) begin
      n_fail++;
      $display("FAIL wrap_instr_pc: got ok=%b %h want fff", ok, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL wrap_next: got %b@%h want 1@000", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_hlt();
    bit ok;
    bit bad;
    wait_valid(ok);
    n_run++;
    if (!ok || bus.opcode !== 4'h8 || bus.instr_pc !== 12'h000) begin
      n_fail++;
      $display("FAIL hlt_fetch: got ok=%b op %h pc %h want op 8 pc 000",
               ok, bus.opcode, bus.instr_pc);
    end
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h300;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_run++;
    if (bus.halted !== 1'b1 || bus.mem_req !== 1'b0 ||
        bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_enter: got h%b r%b v%b want h1 r0 v0",
               bus.halted, bus.mem_req, bus.instr_valid);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.redirect_valid = i[0];
      bus.redirect_pc = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (bus.halted !== 1'b1 || bus.mem_req !== 1'b0 ||
          bus.instr_valid !== 1'b0) bad = 1'b1;
    end
    bus.redirect_valid = 1'b0;
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL hlt_stay: got left halt state want halted");
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.halted !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_reset: got h%b r%b want h0 r0", bus.halted, bus.mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h100) begin
      n_fail++;
      $display("FAIL hlt_restart: got %b@%h want 1@100", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_reset_in_hold();
    bit ok;
    bus.instr_ready = 1'b0;
    wait_valid(ok);
    n_run++;
    if (!ok) begin
      n_fail++; $display("FAIL hold_reach: got no valid want valid");
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.instr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v%b r%b %h want v0 r0 0",
               bus.instr_valid, bus.mem_req, bus.instr);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [11:0] exp_pc;
    logic [11:0] prev_addr;
    bit prev_pend;
    bit hs;
    bit redir;
    logic [11:0] rpc;
    int n_hs;
    rst_n = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      w = $urandom;
      if (w[31:28] == 4'h8) w[31:28] = 4'h9;
      mem[a] = w;
    end
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 12'h100;
    prev_pend = 1'b0;
    prev_addr = '0;
    n_hs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_pend) begin
        n_run++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL rnd_req_hold: got %b@%h want 1@%h",
                   bus.mem_req, bus.mem_addr, prev_addr);
        end
      end
      prev_pend = bus.mem_req && !bus.mem_ack;
      prev_addr = bus.mem_addr;
      if (!bus.mem_req) waits = $urandom_range(0, 3);
      bus.instr_ready = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 15) == 0);
      rpc = 12'($urandom_range(0, 4095));
      bus.redirect_valid = redir;
      bus.redirect_pc = rpc;
      hs = (bus.instr_valid === 1'b1) && bus.instr_ready;
      if (hs) begin
        w = mem[exp_pc];
        n_hs++;
        n_run++;
        if (bus.instr !== w || bus.instr_pc !== exp_pc ||
            bus.opcode !== 4'((w >> 28) & 32'hF) ||
            bus.cond !== 4'((w >> 24) & 32'hF) ||
            bus.src_field !== 12'((w >> 12) & 32'hFFF) ||
            bus.dst_field !== 12'(w & 32'hFFF)) begin
          n_fail++;
          $display("FAIL rnd_handoff: got %h@%h want %h@%h",
                   bus.instr, bus.instr_pc, w, exp_pc);
        end
      end
      if (redir)   exp_pc = rpc;
      else if (hs) exp_pc = exp_pc + 12'h001;
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b0;
    n_run++;
    if (n_hs < 200) begin
      n_fail++;
      $display("FAIL rnd_throughput: got %0d handoffs want >=200", n_hs);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 32'h1000_0000 | 32'(a);
    mem[12'h100] = 32'h1000_5006;
    mem[12'h101] = 32'h5A12_3456;
    mem[12'h102] = 32'h2000_0102;
    mem[12'h200] = 32'h4300_0ABC;
    mem[12'hFFF] = 32'h7C00_1FFF;
    mem[12'h000] = 32'h8000_0000;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_wrap();
    test_hlt();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
